mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Multi-cycle data-memory access sequencer for the MEM stage of the MIPS datapath.
- Accepts one load or store request per transaction and drives a word-wide, variable-latency data memory through a valid/ready handshake.
- Loads: extracts the byte, halfword or word and zero-extends it, with lane selection on addr[1:0]. This matches the lb/lh/lw zero-extension the load path already implements.
- Stores: word stores are written directly; byte and halfword stores use read-modify-write. Misaligned accesses, illegal sizes and memory timeouts are flagged.

Parameters:
- TIMEOUT, 255: maximum cycles to wait for mem_ready per memory phase; 0 disables the timeout.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; held stable by the requester until resp_valid.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (same encoding as load_signal).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; sub-word data is in the low bits.
- req_ready  out  1  high in IDLE.
- stall  out  1  pipeline hold.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  zero-extended load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, illegal size or timeout.
- mem_en  out  1  memory request.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  read data, valid when mem_ready.
- mem_ready  in  1  memory completes the current phase this cycle.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - state goes to IDLE.
  - mem_en=0, mem_we=0, resp_valid=0, resp_err=0.
  - resp_rdata=0, mem_addr=0, mem_wdata=0.
  - Timeout counter = 0.
  - Reset mid-transaction abandons the access with no response; mem_en is low from the cycle after the reset edge.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - If req_valid, register addr, size, store and wdata.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) or size 11 -> RESP with err=1; the memory is never touched.
  - Word store -> WRITE.
  - Any other legal request (all loads, byte/half stores) -> READ.
- READ:
  - Drives mem_en=1, mem_we=0, mem_addr held stable.
  - On mem_ready, for a load: capture the extracted lane into resp_rdata -> RESP.
    - byte = mem_rdata[8*off+7 : 8*off], off = addr[1:0].
    - half = mem_rdata[16*addr[1]+15 : 16*addr[1]].
    - Upper bits are zero.
  - On mem_ready, for a store: mem_wdata = mem_rdata with the target byte/half lane replaced by req_wdata low bits -> WRITE.
- WRITE:
  - Drives mem_en=1, mem_we=1, mem_wdata held stable.
  - On mem_ready -> RESP, err=0.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - mem_en=0.
- stall = req_valid & ~resp_valid (combinational). The requester advances on resp_valid and drops or replaces its request the next cycle.
- req_valid while not in IDLE is ignored, never re-latched.
- Timeout counter:
  - Cleared on entry to READ/WRITE, increments each cycle mem_ready is low.
  - If TIMEOUT!=0 and the count reaches TIMEOUT -> RESP with err=1 and resp_rdata=0; mem_en drops.
  - mem_ready arriving in the same cycle as the timeout wins (normal completion).
- Minimum latency, request accepted at cycle T with mem_ready=1 immediately:
  - Load or word store: resp_valid at T+2.
  - Sub-word store: resp_valid at T+3.
  - Error: resp_valid at T+1.
- mem_ready outside READ/WRITE is ignored.

Decomposition:
- Shared package mips_mem_pkg:
  - Size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_ILL=2'b11 (also reused by the load path).
  - The state encoding.
- One combinational sub-module, subword_lane: given word, wdata, size and offset, produces the zero-extended extracted value and the merged write word.
- FSM and timeout counter stay in mem_access_ctrl.

Test Plan:
- Load byte, addr=0x1003, mem_rdata=0xA1B2C3D4, mem_ready high on first cycle -> mem_addr=0x1000, resp_valid at T+2, resp_rdata=0x000000A1, err=0.
- Load half, addr=0x2002, mem_rdata=0x8765_4321, mem_ready delayed 3 cycles -> mem_en held 4 cycles with stable address, resp_rdata=0x00008765, stall high until the resp cycle.
- Store byte, addr=0x10 offset 1, wdata=0xFF, old word 0x11223344 -> read phase, then write phase with mem_we=1 and mem_wdata=0x1122FF44, resp_valid at T+3.
- Word load at addr=0x6 and size=11 -> resp_err=1 at T+1, mem_en never asserted, resp_rdata=0.
- TIMEOUT=4 with mem_ready held low -> err=1 after 4 wait cycles, mem_en low, FSM back in IDLE the following cycle.
- reset asserted during WRITE wait -> next cycle mem_en=0, no resp_valid, req_ready=1; a new load then completes normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared access-size encoding and MEM-stage sequencer states
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } memState_t;

  // A request that must be answered with an error without touching memory.
  function automatic logic isBadReq(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_ILL) ||
           (size == SZ_HALF && off[0]) ||
           (size == SZ_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/subword_lane.sv
// rtl/subword_lane.sv - byte/halfword lane extraction and merge for one memory word
module subword_lane
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] extracted,
  output logic [31:0] merged
);

  logic [4:0] bytePos;
  logic [4:0] halfPos;

  assign bytePos = {offset, 3'b000};
  assign halfPos = {offset[1], 4'b0000};

  always_comb begin
    extracted = word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        extracted = {24'h0, word[bytePos +: 8]};
        merged    = word;
        merged[bytePos +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        extracted = {16'h0, word[halfPos +: 16]};
        merged    = word;
        merged[halfPos +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - multi-cycle load/store sequencer with read-modify-write and timeout
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  memState_t        state;
  memState_t        stateNext;
  logic             storeQ;
  logic [1:0]       sizeQ;
  logic [1:0]       offQ;
  logic [31:0]      wdataQ;
  logic             errQ;
  logic [CNT_W-1:0] waitCnt;
  logic             memPhase;
  logic             timeoutHit;
  logic [31:0]      laneExtracted;
  logic [31:0]      laneMerged;

  subword_lane uLane (
    .word      (mem_rdata),
    .wdata     (wdataQ),
    .size      (sizeQ),
    .offset    (offQ),
    .extracted (laneExtracted),
    .merged    (laneMerged)
  );

  assign memPhase = (state == ST_READ) || (state == ST_WRITE);
  // Fires on the TIMEOUT-th consecutive wait cycle; a same-cycle mem_ready wins.
  assign timeoutHit = (TIMEOUT != 0) && memPhase && !mem_ready && (waitCnt == CNT_LAST);
  assign stall = req_valid & ~resp_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (isBadReq(req_size, req_addr[1:0]))        stateNext = ST_RESP;
          else if (req_store && req_size == SZ_WORD)   stateNext = ST_WRITE;
          else                                         stateNext = ST_READ;
        end
      end
      ST_READ: begin
        if (mem_ready)       stateNext = storeQ ? ST_WRITE : ST_RESP;
        else if (timeoutHit) stateNext = ST_RESP;
      end
      ST_WRITE: begin
        if (mem_ready || timeoutHit) stateNext = ST_RESP;
      end
      ST_RESP: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (state)
      ST_IDLE:  req_ready = 1'b1;
      ST_READ:  mem_en = 1'b1;
      ST_WRITE: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = errQ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      storeQ     <= 1'b0;
      sizeQ      <= SZ_BYTE;
      offQ       <= 2'b00;
      wdataQ     <= 32'h0;
      errQ       <= 1'b0;
      resp_rdata <= 32'h0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
      waitCnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            storeQ     <= req_store;
            sizeQ      <= req_size;
            offQ       <= req_addr[1:0];
            wdataQ     <= req_wdata;
            errQ       <= isBadReq(req_size, req_addr[1:0]);
            resp_rdata <= 32'h0;
            mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata  <= req_wdata;
          end
        end
        ST_READ: begin
          if (mem_ready) begin
            if (storeQ) mem_wdata  <= laneMerged;
            else        resp_rdata <= laneExtracted;
          end else if (timeoutHit) begin
            errQ <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (timeoutHit) errQ <= 1'b1;
        end
        default: ;
      endcase

      // Any state change (including READ -> WRITE) starts a fresh wait count.
      if (stateNext != state)       waitCnt <= '0;
      else if (memPhase && !mem_ready) waitCnt <= waitCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a variable-latency memory model
module tb_mem_access_ctrl;
  import mips_mem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } expResp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_store;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int respCount = 0;
  int memEnCnt = 0;
  int writeCnt = 0;
  int readyDelay = 0;
  int phaseCnt = 0;
  bit holdLow = 0;
  logic [31:0] curAddr = 32'h0;
  logic [31:0] memArr [logic [31:0]];
  expResp_t sb [$];

  mem_access_ctrl #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_store  (req_store),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [31:0] extractModel(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] off);
    if (sz == SZ_BYTE) return (w >> (8 * off)) & 32'hFF;
    if (sz == SZ_HALF) return (w >> (16 * off[1])) & 32'hFFFF;
    return w;
  endfunction

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return memArr.exists(a) ? memArr[a] : 32'h0;
  endfunction

  always @(posedge clk) cycle <= cycle + 1;

  // Memory model: ready after readyDelay wait cycles in each phase; writes land on completion.
  always @(negedge clk) begin
    if (!mem_en) begin
      phaseCnt  = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
    end else begin
      mem_ready = !holdLow && (phaseCnt >= readyDelay);
      mem_rdata = memRead(mem_addr);
      if (mem_ready && mem_we) begin
        memArr[mem_addr] = mem_wdata;
        writeCnt++;
      end
      phaseCnt = mem_ready ? 0 : phaseCnt + 1;
    end
  end

  // Response monitor and scoreboard.
  always @(posedge clk) begin
    expResp_t e;
    #1;
    if (mem_en) begin
      memEnCnt++;
      checkEq("mem_addr", mem_addr, curAddr);
    end
    checkEq("stall", {31'h0, stall}, {31'h0, req_valid & !resp_valid});
    if (resp_valid) begin
      respCount++;
      if (sb.size() == 0) begin
        checkEq("unexpected_resp", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        checkEq("resp_rdata", resp_rdata, e.rdata);
        checkEq("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        checkEq("latency", cycle - e.acc, e.lat);
        checkEq("resp_mem_en", {31'h0, mem_en}, 32'h0);
      end
    end
  end

  task automatic doReq(input bit st, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int d, input logic [31:0] expR,
                       input logic expE, input int expLat);
    int start;
    @(negedge clk);
    readyDelay = d;
    req_store  = st;
    req_size   = sz;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    curAddr    = {a[31:2], 2'b00};
    memEnCnt   = 0;
    sb.push_back('{expR, expE, expLat, cycle});
    start = respCount;
    for (int i = 0; i < 40 && respCount == start; i++) begin
      @(posedge clk);
      #2;
    end
    if (respCount == start) checkEq("resp_wait", 32'h0, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    checkEq("idle_ready", {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0;
    reset = 1'b1;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_size  = SZ_BYTE;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    memArr[32'h1000] = 32'hA1B2C3D4;
    memArr[32'h2000] = 32'h87654321;
    memArr[32'h0010] = 32'h11223344;
    for (int i = 0; i < 4; i++) memArr[32'h100 + 4 * i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    checkEq("rst_req_ready", {31'h0, req_ready}, 32'h1);
    checkEq("rst_mem_en", {31'h0, mem_en}, 32'h0);
    checkEq("rst_mem_we", {31'h0, mem_we}, 32'h0);
    checkEq("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkEq("rst_resp_err", {31'h0, resp_err}, 32'h0);
    checkEq("rst_resp_rdata", resp_rdata, 32'h0);
    checkEq("rst_mem_addr", mem_addr, 32'h0);
    checkEq("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    doReq(0, SZ_BYTE, 32'h1003, 32'h0, 0, 32'h000000A1, 0, 2);
    doReq(0, SZ_HALF, 32'h2002, 32'h0, 3, 32'h00008765, 0, 5);
    checkEq("half_mem_en_cycles", memEnCnt, 4);

    w0 = writeCnt;
    doReq(1, SZ_BYTE, 32'h0011, 32'h000000FF, 0, 32'h0, 0, 3);
    checkEq("sb_write_count", writeCnt - w0, 1);
    checkEq("sb_mem_word", memRead(32'h10), 32'h1122FF44);

    doReq(1, SZ_HALF, 32'h0012, 32'h1234BEEF, 1, 32'h0, 0, 5);
    checkEq("sh_mem_word", memRead(32'h10), 32'hBEEFFF44);

    doReq(1, SZ_WORD, 32'h3000, 32'hCAFEF00D, 1, 32'h0, 0, 3);
    checkEq("sw_mem_word", memRead(32'h3000), 32'hCAFEF00D);

    doReq(0, SZ_WORD, 32'h0006, 32'h0, 0, 32'h0, 1, 1);
    checkEq("mis_word_no_mem", memEnCnt, 0);
    doReq(0, SZ_ILL, 32'h1000, 32'h0, 0, 32'h0, 1, 1);
    checkEq("ill_size_no_mem", memEnCnt, 0);
    w0 = writeCnt;
    doReq(1, SZ_HALF, 32'h0013, 32'hFFFF, 0, 32'h0, 1, 1);
    checkEq("mis_half_no_mem", memEnCnt, 0);
    checkEq("mis_half_no_write", writeCnt - w0, 0);

    doReq(0, SZ_WORD, 32'h1000, 32'h0, 0, 32'hA1B2C3D4, 0, 2);

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          d;
      sz = 2'($urandom_range(2, 0));
      a  = 32'h100 + 32'(4 * $urandom_range(3, 0));
      if (sz == SZ_BYTE)      a[1:0] = 2'($urandom_range(3, 0));
      else if (sz == SZ_HALF) a[1:0] = {1'($urandom_range(1, 0)), 1'b0};
      d = $urandom_range(3, 0);
      doReq(0, sz, a, 32'h0, d, extractModel(memRead({a[31:2], 2'b00}), sz, a[1:0]), 0, 2 + d);
    end

    holdLow = 1;
    doReq(0, SZ_WORD, 32'h0040, 32'h0, 0, 32'h0, 1, 5);
    checkEq("timeout_mem_en_cycles", memEnCnt, 4);
    holdLow = 0;

    // Reset in the middle of a stalled word write.
    holdLow = 1;
    w0 = respCount;
    @(negedge clk);
    req_store = 1'b1;
    req_size  = SZ_WORD;
    req_addr  = 32'h0080;
    req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1;
    curAddr   = 32'h0080;
    repeat (3) @(negedge clk);
    checkEq("pre_rst_in_write", {31'h0, mem_we}, 32'h1);
    reset = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    checkEq("post_rst_mem_en", {31'h0, mem_en}, 32'h0);
    checkEq("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    holdLow = 0;
    repeat (2) @(posedge clk);
    #2;
    checkEq("post_rst_no_resp", respCount - w0, 0);
    checkEq("post_rst_no_write", {31'h0, memArr.exists(32'h80)}, 32'h0);
    doReq(0, SZ_HALF, 32'h1000, 32'h0, 0, 32'h0000C3D4, 0, 2);

    repeat (2) @(posedge clk);
    checkEq("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
